// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration master: frame geometry,
// FSM state encoding and the peripheral register map.
package spi_cfg_pkg;

    localparam int FRAME_BITS = 15;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    // Peripheral register addresses
    localparam logic [ADDR_W-1:0] EN_OUT_LO = 7'd0;
    localparam logic [ADDR_W-1:0] EN_OUT_HI = 7'd1;
    localparam logic [ADDR_W-1:0] EN_PWM_LO = 7'd2;
    localparam logic [ADDR_W-1:0] EN_PWM_HI = 7'd3;
    localparam logic [ADDR_W-1:0] PWM_DUTY  = 7'd4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_e;

    // Address goes out first, so it occupies the top of the frame.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [ADDR_W-1:0] addr,
                                                         input logic [DATA_W-1:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Command FIFO: one-bit-extended pointers give full/empty without a
// separate counter; ready is registered from next-state pointers.
module cfg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     ready_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         ready_q, ready_d;
    logic         do_push, do_pop;

    // Push is gated by the registered ready, so a same-cycle pop never
    // opens a slot for a push while full.
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wptr_q == rptr_q);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign ready_o = ready_q;

    // Next pointers and next-cycle full indication
    always_comb begin
        wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
        ready_d = !((wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
    end

    // Pointer and ready registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ready_q <= ready_d;
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/spi_config_master.sv
// SPI write-only configuration master: drains queued register writes as
// 15-bit frames (addr then data, MSB first), SCLK idle low, data changed
// on the falling edge so the peripheral can sample on the rising edge.
module spi_config_master
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [DATA_W-1:0]             cmd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          done,
    output logic                          sclk,
    output logic                          ncs,
    output logic                          copi
);

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_e                state_q, state_d;
    logic [7:0]            hcnt_q, hcnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  sclk_q, sclk_d;
    logic                  done_q, done_d;
    logic                  pop;
    logic                  fifo_empty;
    logic [FRAME_BITS-1:0] fifo_rdata;

    cfg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FRAME_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .wdata_i (pack_frame(cmd_addr, cmd_data)),
        .rdata_o (fifo_rdata),
        .ready_o (cmd_ready),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign ncs  = !((state_q == SETUP) || (state_q == SHIFT));
    assign sclk = sclk_q;
    assign copi = ncs ? 1'b0 : sr_q[FRAME_BITS-1];
    assign done = done_q;
    assign busy = (state_q != IDLE) || (fifo_level != '0);

    // Frame sequencing: half-period timing, bit count and shifting
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                bit_d  = '0;
                sclk_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sr_d    = fifo_rdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (hcnt_q == DIV_M1) begin
                    hcnt_d  = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (hcnt_q == DIV_M1) begin
                    hcnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the next bit
                        sclk_d = 1'b0;
                        sr_d   = {sr_q[FRAME_BITS-2:0], 1'b0};
                    end else if (bit_q == LAST_BIT) begin
                        done_d  = 1'b1;
                        state_d = GAP;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        sclk_d = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            GAP: begin
                if (hcnt_q == GAP_M1) begin
                    hcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: a default-parameter instance plus a
// CLK_DIV=6/CS_GAP=1 instance, each watched by a frame monitor.
module tb_spi_config_master;
    import spi_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_ready, busy, done, sclk, ncs, copi;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [2:0] fifo_level;
    logic c6_valid, c6_ready, busy6, done6, sclk6, ncs6, copi6;
    logic [6:0] c6_addr;
    logic [7:0] c6_data;
    logic [2:0] level6;

    always #5 clk = ~clk;

    spi_config_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .fifo_level(fifo_level),
        .busy(busy), .done(done), .sclk(sclk), .ncs(ncs), .copi(copi)
    );

    spi_config_master #(.CLK_DIV(6), .FIFO_DEPTH(4), .CS_GAP(1)) dut6 (
        .clk(clk), .rst(rst), .cmd_valid(c6_valid), .cmd_ready(c6_ready),
        .cmd_addr(c6_addr), .cmd_data(c6_data), .fifo_level(level6),
        .busy(busy6), .done(done6), .sclk(sclk6), .ncs(ncs6), .copi(copi6)
    );

    int checks = 0, errors = 0, cyc = 0;
    int timeouts = 0;
    int last_hs;
    bit mon_en = 0;

    // default-instance monitor state
    logic [14:0] exp_q[$], got_q[$];
    int len_q[$], fall_q[$];
    int done_cnt = 0, viol = 0, bits = 0, low = 0;
    logic [14:0] cap;
    logic p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0;

    // timing-instance monitor state
    logic [14:0] exp6_q[$], got6_q[$];
    int len6_q[$];
    int done6_cnt = 0, viol6 = 0, low6 = 0, run6 = 0, ph_min = 1000, ph_max = 0;
    logic [14:0] cap6;
    logic p_ncs6 = 1'b1, p_sclk6 = 1'b0, p_copi6 = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Default instance: capture bits on sclk rise, ncs low time, fall times
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (done === 1'b1) done_cnt++;
            if (ncs === 1'b0 && p_ncs === 1'b1) begin
                fall_q.push_back(cyc); cap = '0; bits = 0; low = 0;
            end
            if (ncs === 1'b0) begin
                low++;
                if (sclk === 1'b1 && p_sclk === 1'b0) begin cap = {cap[13:0], copi}; bits++; end
                if (sclk === 1'b1 && p_sclk === 1'b1 && copi !== p_copi) viol++;
            end
            if (ncs === 1'b1 && p_ncs === 1'b0) begin got_q.push_back(cap); len_q.push_back(low); end
            p_ncs = ncs; p_sclk = sclk; p_copi = copi;
        end
    end

    // Timing instance: same capture plus min/max sclk phase length
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (done6 === 1'b1) done6_cnt++;
            if (ncs6 === 1'b0) begin
                if (p_ncs6 === 1'b1) begin low6 = 1; run6 = 1; cap6 = '0; end
                else begin
                    low6++;
                    if (sclk6 !== p_sclk6) begin
                        if (run6 < ph_min) ph_min = run6;
                        if (run6 > ph_max) ph_max = run6;
                        run6 = 1;
                    end else run6++;
                end
                if (sclk6 === 1'b1 && p_sclk6 === 1'b0) cap6 = {cap6[13:0], copi6};
                if (sclk6 === 1'b1 && p_sclk6 === 1'b1 && copi6 !== p_copi6) viol6++;
            end else if (p_ncs6 === 1'b0) begin
                got6_q.push_back(cap6); len6_q.push_back(low6);
            end
            p_ncs6 = ncs6; p_sclk6 = sclk6; p_copi6 = copi6;
        end
    end

    task automatic push(input logic [6:0] a, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
        while (cmd_ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        if (cmd_ready !== 1'b1) timeouts++;
        last_hs = cyc;
        exp_q.push_back({a, d});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (got_q.size() < n && t < budget) begin @(negedge clk); t++; end
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy !== 1'b0 && t < budget) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear();
        exp_q.delete(); got_q.delete(); len_q.delete(); fall_q.delete();
        timeouts = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_addr = 7'h11; cmd_data = 8'h22;
        c6_valid = 1'b0; c6_addr = '0; c6_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL reset_ncs got=%b exp=1", ncs); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (copi !== 1'b0) begin errors++; $display("FAIL reset_copi got=%b exp=0", copi); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        mon_en = 1;
        repeat (4) @(negedge clk);
        checks++; if (fifo_level !== 3'd0 || ncs !== 1'b1)
            begin errors++; $display("FAIL reset_no_accept level=%0d ncs=%b exp level=0 ncs=1", fifo_level, ncs); end
    endtask

    task automatic test_single();
        int d0, hs;
        logic [14:0] e;
        clear(); d0 = done_cnt;
        push(7'h04, 8'hA5); hs = last_hs;
        wait_frames(1, 400); wait_idle(100);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() == 1) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e) begin errors++; $display("FAIL single_frame got=%h exp=%h", got_q[0], e); end
            checks++; if (fall_q[0] - hs != 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", fall_q[0] - hs); end
            checks++; if (len_q[0] != 124) begin errors++; $display("FAIL single_ncs_low got=%0d exp=124", len_q[0]); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", busy); end
    endtask

    task automatic test_burst();
        int d0, t = 0, nerr = 0;
        logic [14:0] e;
        clear(); d0 = done_cnt;
        push(7'h10, 8'h01);
        while (ncs !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        for (int i = 0; i < 4; i++) push(7'(i), 8'h30 + 8'(i));
        checks++; if (cmd_ready !== 1'b0 || fifo_level !== 3'd4)
            begin errors++; $display("FAIL burst_full ready=%b level=%0d exp ready=0 level=4", cmd_ready, fifo_level); end
        wait_frames(5, 1000); wait_idle(200);
        checks++; if (got_q.size() != 5 || timeouts != 0)
            begin errors++; $display("FAIL burst_count got=%0d exp=5 timeouts=%0d", got_q.size(), timeouts); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e) begin errors++; $display("FAIL burst_frame got=%h exp=%h", got_q[0], e); end
            void'(got_q.pop_front());
        end
        for (int i = 1; i < fall_q.size(); i++)
            if (fall_q[i] - fall_q[i-1] != 133) nerr++;
        checks++; if (nerr != 0 || fall_q.size() != 5)
            begin errors++; $display("FAIL burst_spacing bad=%0d falls=%0d exp 0 bad 5 falls spaced 133", nerr, fall_q.size()); end
        checks++; if (done_cnt - d0 != 5) begin errors++; $display("FAIL burst_done got=%0d exp=5", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full_stall();
        int d0;
        logic [14:0] e;
        clear(); d0 = done_cnt;
        for (int i = 0; i < 6; i++) push(7'h08 + 7'(i), 8'($urandom_range(0, 255)));
        checks++; if (fall_q.size() < 2 || last_hs != fall_q[1])
            begin errors++; $display("FAIL stall_accept got=%0d exp=%0d", last_hs, (fall_q.size() < 2) ? -1 : fall_q[1]); end
        wait_frames(6, 1200); wait_idle(200);
        checks++; if (got_q.size() != 6 || timeouts != 0)
            begin errors++; $display("FAIL stall_count got=%0d exp=6 timeouts=%0d", got_q.size(), timeouts); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e) begin errors++; $display("FAIL stall_frame got=%h exp=%h", got_q[0], e); end
            void'(got_q.pop_front());
        end
        checks++; if (done_cnt - d0 != 6) begin errors++; $display("FAIL stall_done got=%0d exp=6", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int d0, nf, t = 0;
        clear();
        for (int i = 0; i < 3; i++) push(7'h20 + 7'(i), 8'h5A);
        while (bits < 7 && t < 200) begin @(negedge clk); t++; end
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (ncs !== 1'b1 || sclk !== 1'b0)
            begin errors++; $display("FAIL abort_pins ncs=%b sclk=%b exp ncs=1 sclk=0", ncs, sclk); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL abort_level got=%0d exp=0", fifo_level); end
        @(negedge clk);
        rst = 1'b0;
        nf = fall_q.size();
        repeat (500) @(negedge clk);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done got=%0d exp=%0d", done_cnt, d0); end
        checks++; if (fall_q.size() != nf || busy !== 1'b0)
            begin errors++; $display("FAIL abort_no_frames falls=%0d exp=%0d busy=%b", fall_q.size(), nf, busy); end
        clear();
    endtask

    task automatic test_unused_addr();
        int d0;
        logic [14:0] e;
        clear(); d0 = done_cnt;
        push(7'h7F, 8'h00);
        wait_frames(1, 400); wait_idle(100);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL unused_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() == 1) begin
            e = exp_q.pop_front();
            checks++; if (got_q[0] !== e || got_q[0] !== 15'h7F00)
                begin errors++; $display("FAIL unused_frame got=%h exp=%h", got_q[0], e); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL unused_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_timing();
        int t = 0;
        logic [14:0] e;
        @(negedge clk);
        checks++; if (c6_ready !== 1'b1) begin errors++; $display("FAIL t6_ready got=%b exp=1", c6_ready); end
        c6_valid = 1'b1; c6_addr = EN_PWM_HI; c6_data = 8'h3C;
        exp6_q.push_back({EN_PWM_HI, 8'h3C});
        @(posedge clk); #1 c6_valid = 1'b0;
        while (got6_q.size() < 1 && t < 500) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        checks++; if (got6_q.size() != 1) begin errors++; $display("FAIL t6_count got=%0d exp=1", got6_q.size()); end
        if (got6_q.size() == 1) begin
            e = exp6_q.pop_front();
            checks++; if (got6_q[0] !== e) begin errors++; $display("FAIL t6_frame got=%h exp=%h", got6_q[0], e); end
            checks++; if (len6_q[0] != 186) begin errors++; $display("FAIL t6_ncs_low got=%0d exp=186", len6_q[0]); end
        end
        checks++; if (ph_min != 6 || ph_max != 6)
            begin errors++; $display("FAIL t6_phase min=%0d max=%0d exp=6", ph_min, ph_max); end
        checks++; if (viol6 != 0 || viol != 0)
            begin errors++; $display("FAIL copi_stable viol6=%0d viol=%0d exp=0", viol6, viol); end
        checks++; if (done6_cnt != 1) begin errors++; $display("FAIL t6_done got=%0d exp=1", done6_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_stall();
        test_reset_mid();
        test_unused_addr();
        test_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_config_master.md
SPI_CONFIG_MASTER -- requirements
Module: spi_config_master

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period; legal range 4..255.
REQ-002 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-003 Parameter CS_GAP, default 8, clk cycles nCS held high between frames; legal range 1..255.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  FIFO can accept a command.
REQ-008 cmd_addr  in  7  target register address.
REQ-009 cmd_data  in  8  register write data.
REQ-010 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued commands.
REQ-011 busy  out  1  frame in progress or FIFO non-empty.
REQ-012 done  out  1  one-cycle pulse per completed frame.
REQ-013 sclk  out  1  SPI clock to peripheral; idle low.
REQ-014 ncs  out  1  active-low chip select.
REQ-015 copi  out  1  serial data, MSB first.

Function
REQ-016 A command SHALL be accepted on any cycle with cmd_valid && cmd_ready; cmd_ready SHALL equal !full, registered, so no push occurs while full, even on a cycle with a pop.
REQ-017 Each frame SHALL be 15 bits: {cmd_addr[6:0], cmd_data[7:0]}, bit 14 first; addresses above 4 SHALL be sent unmodified.
REQ-018 FSM states: IDLE, SETUP, SHIFT, GAP.
REQ-019 IDLE: ncs=1, sclk=0, copi=0; when FIFO non-empty, pop the head, load the shift register, and enter SETUP with ncs=0 and copi=bit 14 from the next cycle.
REQ-020 A command pushed into an empty FIFO while IDLE SHALL produce ncs=0 two cycles after the handshake cycle.
REQ-021 SETUP: hold sclk=0 and ncs=0 for CLK_DIV cycles, then enter SHIFT.
REQ-022 SHIFT: per bit, sclk high for CLK_DIV cycles, then low for CLK_DIV cycles; copi SHALL change only on the cycle sclk falls, and stays stable throughout each high phase.
REQ-023 After the 15th low phase, the FSM SHALL drive ncs=1, pulse done for exactly that cycle, and enter GAP.
REQ-024 ncs low time SHALL be exactly 31*CLK_DIV cycles per frame; with defaults, 124 cycles.
REQ-025 GAP: hold ncs=1, sclk=0, copi=0 for CS_GAP cycles, then enter IDLE.
REQ-026 Back-to-back queued frames SHALL have ncs falling edges 31*CLK_DIV+CS_GAP+1 cycles apart; with defaults, 133 cycles.
REQ-027 fifo_level SHALL update the cycle after a push or pop; a simultaneous push and pop SHALL leave it unchanged.
REQ-028 busy SHALL be combinationally (state!=IDLE) || (fifo_level!=0).
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from a one-bit-extended pointer compare.

Reset
REQ-030 On a clk edge with rst=1, the block SHALL enter IDLE, empty the FIFO, and drive ncs=1, sclk=0, copi=0, done=0, cmd_ready=1, fifo_level=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; ncs SHALL rise on the next edge; the aborted command SHALL be discarded and not retried.
REQ-032 A command offered on a reset cycle SHALL NOT be accepted.

Structure
REQ-033 Shared package spi_cfg_pkg SHALL hold FRAME_BITS=15, ADDR_W=7, DATA_W=8, the FSM state enumeration, and register address constants: EN_OUT_LO=0, EN_OUT_HI=1, EN_PWM_LO=2, EN_PWM_HI=3, PWM_DUTY=4.
REQ-034 The command FIFO SHALL be a sub-module cfg_cmd_fifo, 15 bits wide, FIFO_DEPTH deep; the top level SHALL contain the FSM, half-period counter, bit counter and shift register.

Verification
REQ-035 Single write: push addr=0x04, data=0xA5 while idle -> ncs low 2 cycles later; capture on sclk rising edges yields 0x04A5; ncs low 124 cycles; one done pulse.
REQ-036 Burst: push 4 commands (addr 0..3) back-to-back -> cmd_ready low after the 4th; frames emitted in order; ncs falling edges 133 cycles apart; 4 done pulses; busy then drops.
REQ-037 Full-FIFO stall: hold cmd_valid with 5 commands while the first frame is in flight -> 5th accepted only after the first pop; no command lost or duplicated.
REQ-038 Reset mid-frame: assert rst at bit 7 of a frame with 2 queued -> next edge ncs=1, sclk=0, fifo_level=0; no done pulse; no further frames.
REQ-039 Timing: CLK_DIV=6, CS_GAP=1 -> each sclk phase 6 cycles; ncs low 186 cycles; copi never toggles while sclk is high.
REQ-040 Unused address: push addr=0x7F, data=0x00 -> frame 0x7F00 sent unmodified; done pulses.
